// File: rtl/multicycle_control.sv
// Multi-cycle control FSM for the teaching CPU datapath (FETCH/DECODE/EXEC/MEM/WB).
// Optional feature: define PERF_CNT_EN to add the retired_count instruction counter.
module multicycle_control #(
  parameter int unsigned OP_WIDTH    = 3,
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter int unsigned CNT_WIDTH   = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [OP_WIDTH-1:0]  op,
  input  logic                 zero,
  input  logic                 imem_ready,
  input  logic                 dmem_ready,
  input  logic                 stall,
  output logic                 imem_req,
  output logic                 ir_write,
  output logic                 pc_write,
  output logic                 pc_src,
  output logic                 reg_dst,
  output logic                 reg_write,
  output logic                 alu_src,
  output logic [1:0]           alu_op,
  output logic                 mem_read,
  output logic                 mem_write,
  output logic                 mem_to_reg,
  output logic                 halted,
  output logic                 illegal_op,
  output logic                 bus_error
`ifdef PERF_CNT_EN
  ,
  output logic [CNT_WIDTH-1:0] retired_count
`endif
);

  localparam int unsigned WAIT_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;

  localparam logic [OP_WIDTH-1:0] OP_RTYPE = OP_WIDTH'(0);
  localparam logic [OP_WIDTH-1:0] OP_LOAD  = OP_WIDTH'(1);
  localparam logic [OP_WIDTH-1:0] OP_STORE = OP_WIDTH'(2);
  localparam logic [OP_WIDTH-1:0] OP_BEQ   = OP_WIDTH'(3);
  localparam logic [OP_WIDTH-1:0] OP_ADDI  = OP_WIDTH'(4);
  localparam logic [OP_WIDTH-1:0] OP_HALT  = OP_WIDTH'(5);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_HALT,
    S_TRAP
  } state_t;

  state_t              state_q, state_d;
  logic [OP_WIDTH-1:0] op_q, op_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  logic                illegal_q, illegal_d;
  logic                bus_err_q, bus_err_d;
  logic                timeout_hit;
  logic                stall_active;

  assign timeout_hit  = (MEM_TIMEOUT != 0) && (wait_q == WAIT_W'(MEM_TIMEOUT));
  assign stall_active = stall && (state_q != S_IDLE) && (state_q != S_HALT) && (state_q != S_TRAP);
  assign illegal_op   = illegal_q;
  assign bus_error    = bus_err_q;

  // State, latched opcode, wait counter and sticky trap causes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      op_q      <= '0;
      wait_q    <= '0;
      illegal_q <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      wait_q    <= wait_d;
      illegal_q <= illegal_d;
      bus_err_q <= bus_err_d;
    end
  end

  // Next state and control outputs decoded from the current state
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    wait_d     = wait_q;
    illegal_d  = illegal_q;
    bus_err_d  = bus_err_q;
    imem_req   = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = 1'b0;
    reg_dst    = 1'b0;
    reg_write  = 1'b0;
    alu_src    = 1'b0;
    alu_op     = 2'b00;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_to_reg = 1'b0;
    halted     = 1'b0;

    case (state_q)
      S_IDLE: state_d = S_FETCH;

      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = S_DECODE;
        end else if (timeout_hit) begin
          state_d   = S_TRAP;
          bus_err_d = 1'b1;
        end else if (MEM_TIMEOUT != 0) begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end

      S_DECODE: begin
        op_d = op;
        if ((op == OP_RTYPE) || (op == OP_LOAD) || (op == OP_STORE) ||
            (op == OP_BEQ) || (op == OP_ADDI)) begin
          state_d = S_EXEC;
        end else if (op == OP_HALT) begin
          state_d = S_HALT;
        end else begin
          state_d   = S_TRAP;
          illegal_d = 1'b1;
        end
      end

      S_EXEC: begin
        if (op_q == OP_RTYPE) begin
          alu_op  = 2'b10;
          state_d = S_WB;
        end else if (op_q == OP_ADDI) begin
          alu_src = 1'b1;
          state_d = S_WB;
        end else if ((op_q == OP_LOAD) || (op_q == OP_STORE)) begin
          alu_src = 1'b1;
          state_d = S_MEM;
        end else if (op_q == OP_BEQ) begin
          alu_op   = 2'b01;
          pc_src   = 1'b1;
          pc_write = zero;
          state_d  = S_FETCH;
        end else begin
          state_d   = S_TRAP;
          illegal_d = 1'b1;
        end
      end

      S_MEM: begin
        alu_src = 1'b1;
        if (op_q == OP_STORE) mem_write = 1'b1;
        else                  mem_read  = 1'b1;
        if (dmem_ready) begin
          state_d = (op_q == OP_STORE) ? S_FETCH : S_WB;
        end else if (timeout_hit) begin
          state_d   = S_TRAP;
          bus_err_d = 1'b1;
        end else if (MEM_TIMEOUT != 0) begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end

      S_WB: begin
        reg_write  = 1'b1;
        reg_dst    = (op_q == OP_RTYPE);
        mem_to_reg = (op_q == OP_LOAD);
        state_d    = S_FETCH;
      end

      S_HALT: halted = 1'b1;

      S_TRAP: ;

      default: state_d = S_IDLE;
    endcase

    if (state_d != state_q) wait_d = '0;

    // Stall freezes all sequential state and suppresses side-effecting strobes
    if (stall_active) begin
      state_d   = state_q;
      op_d      = op_q;
      wait_d    = wait_q;
      illegal_d = illegal_q;
      bus_err_d = bus_err_q;
      imem_req  = 1'b0;
      ir_write  = 1'b0;
      pc_write  = 1'b0;
      reg_write = 1'b0;
      mem_read  = 1'b0;
      mem_write = 1'b0;
    end
  end

`ifdef PERF_CNT_EN
  logic                 retire;
  logic [CNT_WIDTH-1:0] retired_q;

  // An instruction retires on WB exit, STORE completion or BEQ execution
  assign retire = !stall &&
                  ((state_q == S_WB) ||
                   ((state_q == S_MEM) && (op_q == OP_STORE) && dmem_ready) ||
                   ((state_q == S_EXEC) && (op_q == OP_BEQ)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) retired_q <= '0;
    else if (retire) retired_q <= retired_q + CNT_WIDTH'(1);
  end

  assign retired_count = retired_q;
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: instruction-level reference expanded
// into expected per-cycle control vectors under randomized waits, stalls and noise.
module tb_multicycle_control;

  localparam int unsigned OP_WIDTH    = 3;
  localparam int unsigned MEM_TIMEOUT = 15;
  localparam int unsigned CNT_WIDTH   = 32;

  localparam int OP_RTYPE = 0;
  localparam int OP_LOAD  = 1;
  localparam int OP_STORE = 2;
  localparam int OP_BEQ   = 3;
  localparam int OP_ADDI  = 4;
  localparam int OP_HALT  = 5;

  typedef struct packed {
    logic       imem_req;
    logic       ir_write;
    logic       pc_write;
    logic       pc_src;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src;
    logic [1:0] alu_op;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       halted;
    logic       illegal_op;
    logic       bus_error;
  } ctl_t;

  logic                clk = 1'b0;
  logic                rst_n = 1'b1;
  logic [OP_WIDTH-1:0] op = '0;
  logic                zero = 1'b0;
  logic                imem_ready = 1'b0;
  logic                dmem_ready = 1'b0;
  logic                stall = 1'b0;
  logic                imem_req, ir_write, pc_write, pc_src, reg_dst, reg_write;
  logic                alu_src, mem_read, mem_write, mem_to_reg, halted, illegal_op, bus_error;
  logic [1:0]          alu_op;
`ifdef PERF_CNT_EN
  logic [CNT_WIDTH-1:0] retired_count;
`endif

  int n_total = 0;
  int n_bad   = 0;
  int exp_ret = 0;

  always #5 clk = ~clk;

  multicycle_control #(
    .OP_WIDTH(OP_WIDTH), .MEM_TIMEOUT(MEM_TIMEOUT), .CNT_WIDTH(CNT_WIDTH)
  ) dut (
    .clk(clk), .rst_n(rst_n), .op(op), .zero(zero),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready), .stall(stall),
    .imem_req(imem_req), .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src),
    .reg_dst(reg_dst), .reg_write(reg_write), .alu_src(alu_src), .alu_op(alu_op),
    .mem_read(mem_read), .mem_write(mem_write), .mem_to_reg(mem_to_reg),
    .halted(halted), .illegal_op(illegal_op), .bus_error(bus_error)
`ifdef PERF_CNT_EN
    , .retired_count(retired_count)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic ctl_t obs();
    ctl_t o;
    o.imem_req   = imem_req;   o.ir_write  = ir_write;  o.pc_write   = pc_write;
    o.pc_src     = pc_src;     o.reg_dst   = reg_dst;   o.reg_write  = reg_write;
    o.alu_src    = alu_src;    o.alu_op    = alu_op;    o.mem_read   = mem_read;
    o.mem_write  = mem_write;  o.mem_to_reg = mem_to_reg; o.halted   = halted;
    o.illegal_op = illegal_op; o.bus_error = bus_error;
    return o;
  endfunction

  // Expected control vector for each instruction phase
  function automatic ctl_t fetch_e(input bit st, input bit rdy);
    ctl_t e = '0;
    e.imem_req = !st;
    e.ir_write = !st && rdy;
    e.pc_write = !st && rdy;
    return e;
  endfunction

  function automatic ctl_t exec_e(input int opc, input bit st, input bit zf);
    ctl_t e = '0;
    case (opc)
      OP_RTYPE: e.alu_op = 2'b10;
      OP_BEQ: begin
        e.alu_op = 2'b01; e.pc_src = 1'b1; e.pc_write = zf && !st;
      end
      default: e.alu_src = 1'b1;
    endcase
    return e;
  endfunction

  function automatic ctl_t mem_e(input int opc, input bit st);
    ctl_t e = '0;
    e.alu_src   = 1'b1;
    e.mem_read  = !st && (opc == OP_LOAD);
    e.mem_write = !st && (opc == OP_STORE);
    return e;
  endfunction

  function automatic ctl_t wb_e(input int opc, input bit st);
    ctl_t e = '0;
    e.reg_write  = !st;
    e.reg_dst    = (opc == OP_RTYPE);
    e.mem_to_reg = (opc == OP_LOAD);
    return e;
  endfunction

  function automatic ctl_t flag_e(input bit h, input bit ill, input bit be);
    ctl_t e = '0;
    e.halted = h; e.illegal_op = ill; e.bus_error = be;
    return e;
  endfunction

  // Inputs that the current phase must ignore get random values
  task automatic noise();
    op         = OP_WIDTH'($urandom);
    zero       = 1'($urandom);
    imem_ready = 1'($urandom);
    dmem_ready = 1'($urandom);
  endtask

  // Compare mid-cycle, then advance to just after the next rising edge
  task automatic step(input string tag, input ctl_t e);
    @(negedge clk);
    chk(tag, 32'(obs()), 32'(e));
    @(posedge clk);
    #1;
  endtask

  task automatic chk_ret();
`ifdef PERF_CNT_EN
    chk("retired", 32'(retired_count), 32'(exp_ret));
`endif
  endtask

  task automatic do_reset();
    stall = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rst_async", 32'(obs()), 32'(0));
    exp_ret = 0;
    repeat (2) @(posedge clk);
    #1;
    chk_ret();
    rst_n = 1'b1;
    step("idle", '0);
  endtask

  // Memory wait phase: n_wait non-stalled not-ready cycles and n_stall stalled cycles
  // (ready shown but ignored), interleaved randomly, then optionally the ready cycle.
  task automatic mem_phase(input bit is_fetch, input int opc, input int n_wait,
                           input int n_stall, input bit finish);
    int w = n_wait;
    int s = n_stall;
    bit st;
    while (w + s > 0) begin
      st = (s > 0) && ((w == 0) || ($urandom_range(0, 1) == 1));
      if (st) s--; else w--;
      noise();
      stall = st;
      if (is_fetch) imem_ready = st; else dmem_ready = st;
      step(is_fetch ? "fetch_wait" : "mem_wait", is_fetch ? fetch_e(st, 1'b0) : mem_e(opc, st));
    end
    if (finish) begin
      noise();
      stall = 1'b0;
      if (is_fetch) imem_ready = 1'b1; else dmem_ready = 1'b1;
      step(is_fetch ? "fetch" : "mem", is_fetch ? fetch_e(1'b0, 1'b1) : mem_e(opc, 1'b0));
    end
  endtask

  task automatic stall_cycles(input int n, input string tag, input ctl_t e);
    for (int i = 0; i < n; i++) begin
      noise();
      stall = 1'b1;
      step(tag, e);
    end
    stall = 1'b0;
  endtask

  task automatic run_front(input int opc, input int fw, input int fs, input int st, input bit zf);
    mem_phase(1'b1, 0, fw, fs, 1'b1);
    stall_cycles($urandom_range(0, st), "dec_stall", '0);
    noise();
    op = OP_WIDTH'(opc);
    step("decode", '0);
    stall_cycles($urandom_range(0, st), "exec_stall", exec_e(opc, 1'b1, 1'b0));
    noise();
    zero = zf;
    step("exec", exec_e(opc, 1'b0, zf));
  endtask

  task automatic run_instr(input int opc, input int fw, input int fs, input int mw,
                           input int ms, input int st, input bit zf);
    run_front(opc, fw, fs, st, zf);
    if (opc == OP_LOAD || opc == OP_STORE) mem_phase(1'b0, opc, mw, ms, 1'b1);
    if (opc == OP_RTYPE || opc == OP_LOAD || opc == OP_ADDI) begin
      stall_cycles($urandom_range(0, st), "wb_stall", wb_e(opc, 1'b1));
      noise();
      step("wb", wb_e(opc, 1'b0));
    end
    exp_ret++;
    chk_ret();
  endtask

  task automatic terminal(input string tag, input int n, input ctl_t e);
    for (int i = 0; i < n; i++) begin
      noise();
      stall = 1'($urandom);
      step(tag, e);
    end
    stall = 1'b0;
  endtask

  initial begin
    #2;
    do_reset();

    // Directed plan items
    run_instr(OP_RTYPE, 0, 0, 0, 0, 0, 1'b0);
    run_instr(OP_RTYPE, 0, 5, 0, 0, 0, 1'b0);
    run_instr(OP_LOAD,  0, 0, 3, 0, 0, 1'b0);
    chk("load_no_buserr", 32'(bus_error), 32'(0));
    run_instr(OP_BEQ,   0, 0, 0, 0, 0, 1'b1);
    run_instr(OP_BEQ,   0, 0, 0, 0, 0, 1'b0);
    run_instr(OP_ADDI,  0, 0, 0, 0, 0, 1'b0);
    run_instr(OP_STORE, 0, 0, 0, 0, 0, 1'b0);

    // Randomized instruction stream with waits and stalls
    for (int i = 0; i < 120; i++) begin
      run_instr($urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 2),
                $urandom_range(0, 4), $urandom_range(0, 2), $urandom_range(0, 2),
                1'($urandom));
    end

    // STORE with ready exactly on the limit cycle: no trap
    run_front(OP_STORE, 0, 0, 0, 1'b0);
    mem_phase(1'b0, OP_STORE, MEM_TIMEOUT, 2, 1'b1);
    exp_ret++;
    chk_ret();
    chk("lim_no_trap", 32'(bus_error), 32'(0));
    run_instr(OP_RTYPE, 1, 0, 0, 0, 1, 1'b0);

    // STORE with dmem never ready: trap after the limit
    run_front(OP_STORE, 0, 0, 0, 1'b0);
    mem_phase(1'b0, OP_STORE, MEM_TIMEOUT + 1, 0, 1'b0);
    terminal("trap_mem", 5, flag_e(1'b0, 1'b0, 1'b1));
    chk_ret();
    do_reset();

    // Fetch timeout with stalls interleaved (stalls do not advance the counter)
    mem_phase(1'b1, 0, MEM_TIMEOUT + 1, 4, 1'b0);
    terminal("trap_fetch", 4, flag_e(1'b0, 1'b0, 1'b1));
    do_reset();

    // Illegal opcodes
    run_instr(OP_ADDI, 0, 0, 0, 0, 0, 1'b0);
    mem_phase(1'b1, 0, 0, 0, 1'b1);
    noise();
    op = 3'd7;
    step("decode_ill", '0);
    terminal("trap_ill7", 22, flag_e(1'b0, 1'b1, 1'b0));
    do_reset();
    mem_phase(1'b1, 0, 1, 1, 1'b1);
    noise();
    op = 3'd6;
    step("decode_ill", '0);
    terminal("trap_ill6", 3, flag_e(1'b0, 1'b1, 1'b0));
    do_reset();

    // HALT is terminal and ignores stall
    run_instr(OP_BEQ, 0, 0, 0, 0, 0, 1'b1);
    mem_phase(1'b1, 0, 2, 0, 1'b1);
    noise();
    op = OP_WIDTH'(OP_HALT);
    step("decode_halt", '0);
    terminal("halt", 8, flag_e(1'b1, 1'b0, 1'b0));
    chk_ret();

    // Asynchronous reset in the middle of a fetch wait
    do_reset();
    noise();
    imem_ready = 1'b0;
    #2;
    chk("pre_rst_req", 32'(imem_req), 32'(1));
    do_reset();
    run_instr(OP_RTYPE, 0, 0, 0, 0, 0, 1'b0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
